// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state enum, depth computation and packed-port slice helper for regfile_multi.
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_e;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH = 2**ADDR_W_DEF;
  localparam int SLICE_MAX = 256;
  function automatic int depth_of(input int aw);
    return 2**aw;
  endfunction
  // Field k of width w from a packed vector; callers zero-extend to SLICE_MAX and truncate the result.
  function automatic logic [63:0] port_slice(input logic [SLICE_MAX-1:0] vec, input int w, input int k);
    return 64'(vec >> (k*w)) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequenced bulk-clear engine with busy/done handshake and sticky dropped-write flag.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  input  logic              write,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);
  clr_state_e state, next;
  logic [ADDR_W-1:0] cnt;
  logic last, start;
  assign clr_busy = state == CLEAR;
  assign last = cnt == '1;
  assign start = !clr_busy && clr_req;
  assign clr_en = clr_busy;
  assign clr_addr = cnt;
  always_comb begin
    next = state;
    next = clr_busy ? (last ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      clr_done <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state <= next;
      cnt <= !clr_busy ? '0 : (last ? cnt : cnt + 1'b1);
      clr_done <= clr_busy && last;
      // A write on the accepting edge is dropped too, so setting wins over clearing.
      wr_drop <= (write && (clr_busy || clr_req)) ? 1'b1 : (start ? 1'b0 : wr_drop);
    end
  end
endmodule

// File: rtl/regfile_multi.sv
// regfile_multi: multi-read-port register file with hardwired zero register and bulk clear.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_multi
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rn,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic [ADDR_W-1:0]        wn,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     write,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     wr_drop
);
  localparam int DEPTH_L = depth_of(ADDR_W);
  logic [DATA_W-1:0] regs [DEPTH_L];
  logic clr_en, wr_ok, wz;
  logic [ADDR_W-1:0] clr_addr;
  regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk(clk), .reset(reset), .clr_req(clr_req), .write(write),
    .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop),
    .clr_en(clr_en), .clr_addr(clr_addr)
  );
  assign wz = (ZERO_REG != 0) && (wn == '0);
  assign wr_ok = write && !clr_busy && !clr_req && !wz;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_L; i++) regs[i] <= '0;
    end else if (clr_en) begin
      regs[clr_addr] <= '0;
    end else if (wr_ok) begin
      regs[wn] <= wd;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] q;
    assign ra = ADDR_W'(port_slice(SLICE_MAX'(rn), ADDR_W, k));
    assign q = ((ZERO_REG != 0) && ra == '0) ? '0 : regs[ra];
`ifdef REGFILE_BYPASS_EN
    assign rd[k*DATA_W +: DATA_W] = (write && !clr_busy && wn == ra && !wz) ? wd : q;
`else
    assign rd[k*DATA_W +: DATA_W] = q;
`endif
  end
endmodule

// File: tb/tb_regfile_multi.sv
// tb_regfile_multi: directed self-checking bench for regfile_multi (default parameters).
module tb_regfile_multi;
  logic clk = 1'b0;
  logic reset;
  logic [9:0] rn;
  logic [63:0] rd;
  logic [4:0] wn;
  logic [31:0] wd;
  logic write, clr_req, clr_busy, clr_done, wr_drop;
  int checks = 0;
  int errors = 0;

  regfile_multi dut (
    .clk(clk), .reset(reset), .rn(rn), .rd(rd), .wn(wn), .wd(wd), .write(write),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wn = a; wd = d; write = 1'b1;
    step();
    write = 1'b0;
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!clr_done && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (clr_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done timeout: clr_done=%b required 1", clr_done);
    end
    step();
  endtask

  task automatic test_reset();
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL reset_rd got %h want 0", rd); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", clr_done); end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", wr_drop); end
  endtask

  task automatic test_write();
    rn = {5'd2, 5'd1}; wn = 5'd5; wd = 32'hFFFF_FFFF; write = 1'b0;
    step();
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL write_idle got %h want 0", rd); end
    rn = {5'd2, 5'd5};
    #1;
    checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL write_nowe got %h want 0", rd[31:0]); end
    write = 1'b1;
    step();
    write = 1'b0;
    #1;
    checks++; if (rd[31:0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL write_r5 got %h want ffffffff", rd[31:0]); end
    wr(5'd2, 32'h1111_2222);
    checks++; if (rd[63:32] !== 32'h1111_2222) begin errors++; $display("FAIL write_port1 got %h want 11112222", rd[63:32]); end
  endtask

  task automatic test_zero();
    wr(5'd0, 32'h1234_5678);
    rn = {5'd0, 5'd0};
    #1;
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL zero_reg got %h want 0", rd); end
  endtask

  task automatic test_clear();
    int nb = 0, nd = 0, dj = -1;
    wr(5'd3, 32'hA5A5_A5A5);
    rn = {5'd5, 5'd3};
    #1;
    checks++; if (rd[31:0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL clear_pre got %h want a5a5a5a5", rd[31:0]); end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (clr_busy) nb++;
      if (clr_done) begin nd++; dj = j; end
      if (j == 3) begin
        checks++; if (rd[31:0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL clear_r3_before got %h want a5a5a5a5", rd[31:0]); end
      end
      if (j == 4) begin
        checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL clear_r3_after got %h want 0", rd[31:0]); end
      end
      step();
    end
    checks++; if (nb !== 32) begin errors++; $display("FAIL clear_busy_len got %0d want 32", nb); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL clear_done_count got %0d want 1", nd); end
    checks++; if (dj !== 32) begin errors++; $display("FAIL clear_done_pos got %0d want 32", dj); end
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL clear_drop got %b want 0", wr_drop); end
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL clear_all got %h want 0", rd); end
  endtask

  task automatic test_drop();
    wr(5'd7, 32'h7777_7777);
    rn = {5'd8, 5'd7};
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int j = 0; j < 19; j++) step();
    wr(5'd7, 32'h0000_0BAD);
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_set got %b want 1", wr_drop); end
    wait_done();
    checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL drop_r7 got %h want 0", rd[31:0]); end
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky got %b want 1", wr_drop); end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    #1;
    checks++; if (wr_drop !== 1'b0) begin errors++; $display("FAIL drop_cleared got %b want 0", wr_drop); end
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL drop_busy got %b want 1", clr_busy); end
    wait_done();
    clr_req = 1'b1; write = 1'b1; wn = 5'd8; wd = 32'h8888_8888;
    step();
    clr_req = 1'b0; write = 1'b0;
    #1;
    checks++; if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop_same_edge got %b want 1", wr_drop); end
    wait_done();
    checks++; if (rd[63:32] !== 32'h0) begin errors++; $display("FAIL drop_r8 got %h want 0", rd[63:32]); end
  endtask

  task automatic test_back_to_back();
    int j = 0;
    clr_req = 1'b1;
    step();
    while (!clr_done && j < 60) begin
      step();
      j++;
    end
    checks++; if (j !== 32) begin errors++; $display("FAIL b2b_done_pos got %0d want 32", j); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done got %b want 0", clr_busy); end
    step();
    clr_req = 1'b0;
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %b want 0", clr_done); end
    wait_done();
  endtask

  task automatic test_reset_mid();
    int nd = 0;
    wr(5'd31, 32'h3131_3131);
    wr(5'd20, 32'h2020_2020);
    rn = {5'd20, 5'd31};
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int j = 0; j < 10; j++) step();
    checks++; if (rd !== {32'h2020_2020, 32'h3131_3131}) begin errors++; $display("FAIL mid_pre got %h want 2020202031313131", rd); end
    #2 reset = 1'b0;
    #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", clr_busy); end
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL mid_regs got %h want 0", rd); end
    step();
    reset = 1'b1;
    for (int j = 0; j < 40; j++) begin
      if (clr_done) nd++;
      step();
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", nd); end
  endtask

  task automatic test_bypass();
    wr(5'd9, 32'h0000_0099);
    rn = {5'd9, 5'd0};
    wn = 5'd9; wd = 32'hDEAD_BEEF; write = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (rd[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same got %h want deadbeef", rd[63:32]); end
`else
    checks++; if (rd[63:32] !== 32'h0000_0099) begin errors++; $display("FAIL bypass_old got %h want 00000099", rd[63:32]); end
`endif
    step();
    write = 1'b0;
    #1;
    checks++; if (rd[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_after got %h want deadbeef", rd[63:32]); end
  endtask

  initial begin
    reset = 1'b0; rn = '0; wn = '0; wd = '0; write = 1'b0; clr_req = 1'b0;
    #2;
    test_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    test_write();
    test_zero();
    test_clear();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
